regfile_mp: RTL

Parametrised multi-port successor to the processor's 64-bit register file. It provides NUM_RD asynchronous read ports, two synchronous write ports with per-byte-lane selective write (ppp modes), and optional write-to-read bypass. It also has a sequential clear engine that zeroes the array after reset or on request. It sits in the decode/writeback stages of the pipelined core; entry 0 is hard-wired to zero.

---
 rtl/regfile_pkg.sv | 38 +++
 rtl/regfile_lane_dec.sv | 13 +
 rtl/regfile_mp.sv | 125 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: selective-write mode
// codes, clear-engine states and the byte-lane mask decoder function.
package regfile_pkg;

    localparam logic [2:0] PPP_FULL  = 3'b000;
    localparam logic [2:0] PPP_UHALF = 3'b001;
    localparam logic [2:0] PPP_LHALF = 3'b010;
    localparam logic [2:0] PPP_EVEN  = 3'b011;
    localparam logic [2:0] PPP_ODD   = 3'b100;

    // Widest lane mask the decoder can produce (DATA_W up to 512 bits).
    localparam int MAX_NL = 64;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    // Bit k of the result selects byte lane k, lane 0 being the MSB byte.
    function automatic logic [MAX_NL-1:0] lane_mask(input logic [2:0] ppp, input int nl);
        logic [MAX_NL-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_NL; k++) begin
            if (k < nl) begin
                case (ppp)
                    PPP_FULL:  m[k] = 1'b1;
                    PPP_UHALF: m[k] = (k < nl / 2);
                    PPP_LHALF: m[k] = (k >= nl / 2);
                    PPP_EVEN:  m[k] = (k % 2 == 0);
                    PPP_ODD:   m[k] = (k % 2 == 1);
                    default:   m[k] = 1'b1;  // reserved codes behave as a full write
                endcase
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_lane_dec.sv
// Decodes a selective-write mode into a per-byte-lane write mask.
module regfile_lane_dec
    import regfile_pkg::*;
#(
    parameter int NL = 8
) (
    input  logic [2:0]    ppp_i,
    output logic [NL-1:0] mask_o
);

    assign mask_o = NL'(lane_mask(ppp_i, NL));

endmodule

// File: rtl/regfile_mp.sv
// Multi-port big-endian register file: combinational reads with optional
// write bypass, two byte-selective write ports and a sequential clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
    output logic [0:NUM_RD*DATA_W-1]  rd_data,
    input  logic                      wr0_en,
    input  logic [ADDR_W-1:0]         wr0_addr,
    input  logic [0:DATA_W-1]         wr0_data,
    input  logic [2:0]                wr0_ppp,
    input  logic                      wr1_en,
    input  logic [ADDR_W-1:0]         wr1_addr,
    input  logic [0:DATA_W-1]         wr1_data,
    input  logic [2:0]                wr1_ppp,
    input  logic                      clr_req,
    output logic                      ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NL    = DATA_W / 8;

    typedef logic [0:DATA_W-1] word_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    word_t             mem_q [DEPTH];
    logic [NL-1:0]     mask0, mask1;
    logic              w0_vld, w1_vld, clr_we;

    regfile_lane_dec #(.NL(NL)) u_dec0 (.ppp_i(wr0_ppp), .mask_o(mask0));
    regfile_lane_dec #(.NL(NL)) u_dec1 (.ppp_i(wr1_ppp), .mask_o(mask1));

    assign ready  = (state_q == ST_READY);
    assign clr_we = (state_q == ST_CLEAR);
    assign w0_vld = wr0_en && (wr0_addr != '0) && ready;
    assign w1_vld = wr1_en && (wr1_addr != '0) && ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order processes are evaluated in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= ADDR_W'(1);
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // NOTE: every output of a combinational block is given a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d   = ST_READY;
                    clr_ptr_d = ADDR_W'(1);
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = ADDR_W'(1);
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = ADDR_W'(1);
            end
        endcase
    end

    // NOTE: the storage array has no reset; the clear engine zeroes it after
    // reset release, which keeps it mappable to plain flops or RAM.
    // Entry 0 is never stored; reads of it are forced to zero below.
    always_ff @(posedge clk) begin
        for (int e = 1; e < DEPTH; e++) begin
            if (clr_we && (clr_ptr_q == ADDR_W'(e))) begin
                mem_q[e] <= '0;
            end else begin
                for (int k = 0; k < NL; k++) begin
                    if (w1_vld && (wr1_addr == ADDR_W'(e)) && mask1[k]) begin
                        mem_q[e][8*k +: 8] <= wr1_data[8*k +: 8];
                    end else if (w0_vld && (wr0_addr == ADDR_W'(e)) && mask0[k]) begin
                        mem_q[e][8*k +: 8] <= wr0_data[8*k +: 8];
                    end
                end
            end
        end
    end

    // Address-0 and not-ready forcing take precedence over bypass.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (ready && (rd_addr[p*ADDR_W +: ADDR_W] != '0)) begin
                for (int k = 0; k < NL; k++) begin
                    if ((BYPASS != 0) && w1_vld && mask1[k]
                        && (wr1_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
                        rd_data[p*DATA_W + 8*k +: 8] = wr1_data[8*k +: 8];
                    end else if ((BYPASS != 0) && w0_vld && mask0[k]
                        && (wr0_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
                        rd_data[p*DATA_W + 8*k +: 8] = wr0_data[8*k +: 8];
                    end else begin
                        rd_data[p*DATA_W + 8*k +: 8] =
                            mem_q[rd_addr[p*ADDR_W +: ADDR_W]][8*k +: 8];
                    end
                end
            end
        end
    end

endmodule
